// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and recovers the high time,
// the rise-to-rise period and an 8-bit saturated duty value. If no edge is
// seen for TIMEOUT_CYCLES, the input is flagged as stuck and its level is
// recorded. The first period after reset, or after a stuck condition, is
// always discarded, because its start was not observed.
module pwm_capture #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_count_out,
  output logic [CNT_W-1:0] period_count_out,
  output logic [7:0]       duty_out,
  output logic             valid_out,
  output logic             stuck_out,
  output logic             stuck_level_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DUTY_MAX    = CNT_W'(255);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  logic             sync_s1;
  logic             sync_s2;
  logic             sync_prev;
  logic             rise;
  logic             fall;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_cnt_nxt;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] hi_len_nxt;
  logic [7:0]       hi_duty;
  logic             timeout;

  logic [CNT_W-1:0] high_count_nxt;
  logic [CNT_W-1:0] period_count_nxt;
  logic [7:0]       duty_nxt;
  logic             valid_nxt;
  logic             stuck_nxt;
  logic             stuck_level_nxt;

  // Two-flop synchronizer for the asynchronous input, plus one delayed copy for edge detection
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_s1   <= 1'b0;
      sync_s2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_s1   <= pwm_in;
      sync_s2   <= sync_s1;
      sync_prev <= sync_s2;
    end
  end

  assign rise = sync_s2 & ~sync_prev;
  assign fall = ~sync_s2 & sync_prev;

  // The measurement counter saturates at the timeout value, so it can never wrap
  assign cnt_inc = (cnt >= TIMEOUT_VAL) ? TIMEOUT_VAL : cnt + ONE;

  // Duty value is the high-cycle count clamped to the 8-bit range
  assign hi_duty = (hi_len > DUTY_MAX) ? 8'hFF : hi_len[7:0];

  // Timeout detection. An edge in the same cycle always wins, and IDLE raises at most one timeout until a valid measurement clears stuck
  always_comb begin
    timeout = 1'b0;
    case (state)
      IDLE:    timeout = !stuck_out && (idle_cnt == TIMEOUT_VAL) && !rise && !fall;
      HIGH:    timeout = (cnt == TIMEOUT_VAL) && !fall;
      LOW:     timeout = (cnt == TIMEOUT_VAL) && !rise;
      default: timeout = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next values of the counters and the measurement registers
  always_comb begin
    cnt_nxt          = cnt;
    idle_cnt_nxt     = '0;
    hi_len_nxt       = hi_len;
    high_count_nxt   = high_count_out;
    period_count_nxt = period_count_out;
    duty_nxt         = duty_out;
    valid_nxt        = 1'b0;
    stuck_nxt        = stuck_out;
    stuck_level_nxt  = stuck_level_out;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise || fall) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt >= TIMEOUT_VAL) begin
          idle_cnt_nxt = TIMEOUT_VAL;
        end else begin
          idle_cnt_nxt = idle_cnt + ONE;
        end
        if (rise) begin
          cnt_nxt = ONE;
        end
      end
      HIGH: begin
        cnt_nxt = cnt_inc;
        if (fall) begin
          hi_len_nxt = cnt;
        end
      end
      LOW: begin
        cnt_nxt = cnt_inc;
        if (rise) begin
          high_count_nxt   = hi_len;
          period_count_nxt = cnt;
          duty_nxt         = hi_duty;
          valid_nxt        = 1'b1;
          stuck_nxt        = 1'b0;
          cnt_nxt          = ONE;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase

    if (timeout) begin
      cnt_nxt          = '0;
      idle_cnt_nxt     = TIMEOUT_VAL;
      high_count_nxt   = '0;
      period_count_nxt = '0;
      duty_nxt         = sync_s2 ? 8'hFF : 8'h00;
      valid_nxt        = 1'b1;
      stuck_nxt        = 1'b1;
      stuck_level_nxt  = sync_s2;
    end
  end

  // Counter and measurement registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt              <= '0;
      idle_cnt         <= '0;
      hi_len           <= '0;
      high_count_out   <= '0;
      period_count_out <= '0;
      duty_out         <= '0;
      valid_out        <= 1'b0;
      stuck_out        <= 1'b0;
      stuck_level_out  <= 1'b0;
    end else begin
      cnt              <= cnt_nxt;
      idle_cnt         <= idle_cnt_nxt;
      hi_len           <= hi_len_nxt;
      high_count_out   <= high_count_nxt;
      period_count_out <= period_count_nxt;
      duty_out         <= duty_nxt;
      valid_out        <= valid_nxt;
      stuck_out        <= stuck_nxt;
      stuck_level_out  <= stuck_level_nxt;
    end
  end

endmodule
